// File: rtl/int_reg_write_arbiter_pkg.sv
// int_reg_write_arbiter_pkg: shared types and default sizing for the register write arbiter
package int_reg_write_arbiter_pkg;
    localparam int FIFO_DEPTH_DEFAULT = 2;
    localparam int MAX_WAIT_DEFAULT = 4;
    typedef logic [4:0] reg_addr_t;
    typedef logic [31:0] word_t;
    typedef struct packed {
        reg_addr_t addr;
        word_t value;
    } reg_write_req_t;
endpackage

// File: rtl/int_reg_write_arbiter_if.sv
// int_reg_write_arbiter_if: writeback sources, read-hazard query and register file write port
interface int_reg_write_arbiter_if;
    import int_reg_write_arbiter_pkg::*;
    logic pipeValid;
    reg_addr_t pipeAddr;
    word_t pipeValue;
    logic pipeReady;
    logic longValid;
    reg_addr_t longAddr;
    word_t longValue;
    logic longReady;
    reg_addr_t readAddr1;
    reg_addr_t readAddr2;
    logic readHazard1;
    logic readHazard2;
    logic regWriteEnable;
    reg_addr_t regWriteAddr;
    word_t regWriteValue;
    modport master (
        output pipeValid, pipeAddr, pipeValue, longValid, longAddr, longValue, readAddr1, readAddr2,
        input pipeReady, longReady, readHazard1, readHazard2, regWriteEnable, regWriteAddr, regWriteValue
    );
    modport slave (
        input pipeValid, pipeAddr, pipeValue, longValid, longAddr, longValue, readAddr1, readAddr2,
        output pipeReady, longReady, readHazard1, readHazard2, regWriteEnable, regWriteAddr, regWriteValue
    );
endinterface

// File: rtl/int_reg_write_arbiter_fifo.sv
// int_reg_write_arbiter_fifo: circular buffer of pending long-unit writes with a per-entry address view
module int_reg_write_arbiter_fifo
    import int_reg_write_arbiter_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
    input logic clk,
    input logic rst,
    input logic push,
    input logic pop,
    input reg_write_req_t pushData,
    output reg_write_req_t headData,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [DEPTH-1:0] entryValid,
    output reg_addr_t entryAddr [DEPTH]
);
    localparam int PW = $clog2(DEPTH);
    reg_write_req_t mem [DEPTH];
    logic [PW-1:0] wrPtr, rdPtr;
    assign headData = mem[rdPtr];
    for (genvar i = 0; i < DEPTH; i++) begin : gEntry
        logic [PW-1:0] offset;
        assign offset = PW'(i) - rdPtr;
        assign entryValid[i] = {1'b0, offset} < count;
        assign entryAddr[i] = mem[i].addr;
    end
    // Storage is written only at the tail; contents need no reset since count gates validity.
    always_ff @(posedge clk)
        if (push) mem[wrPtr] <= pushData;
    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk)
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            wrPtr <= wrPtr + PW'(push);
            rdPtr <= rdPtr + PW'(pop);
            count <= count + $bits(count)'(push) - $bits(count)'(pop);
        end
endmodule

// File: rtl/int_reg_write_arbiter.sv
// int_reg_write_arbiter: shares the register file write port between the pipe and the long-unit FIFO
module int_reg_write_arbiter
    import int_reg_write_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input logic clk,
    input logic rst,
    int_reg_write_arbiter_if.slave bus
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(MAX_WAIT + 1);
    logic [CW-1:0] count;
    logic [FIFO_DEPTH-1:0] entryValid, wawMatch, hit1, hit2;
    reg_addr_t entryAddr [FIFO_DEPTH];
    reg_write_req_t head, longReq;
    logic [AW-1:0] age;
    logic forceHead, pipeOk, longOk, pipeGrant, pop, push;
    for (genvar i = 0; i < FIFO_DEPTH; i++) begin : gMatch
        assign wawMatch[i] = entryValid[i] && entryAddr[i] == bus.pipeAddr;
        assign hit1[i] = entryValid[i] && entryAddr[i] == bus.readAddr1;
        assign hit2[i] = entryValid[i] && entryAddr[i] == bus.readAddr2;
    end
    assign forceHead = count != '0 && age == AW'(MAX_WAIT);
    assign pipeOk = !forceHead && !(bus.pipeAddr != '0 && |wawMatch);
    assign longOk = count < CW'(FIFO_DEPTH);
    assign bus.pipeReady = pipeOk;
    assign bus.longReady = longOk;
    assign bus.readHazard1 = bus.readAddr1 != '0 && |hit1;
    assign bus.readHazard2 = bus.readAddr2 != '0 && |hit2;
    assign pipeGrant = bus.pipeValid && pipeOk;
    assign pop = !pipeGrant && count != '0;
    assign push = bus.longValid && longOk && bus.longAddr != '0;
    assign longReq = '{addr: bus.longAddr, value: bus.longValue};
    int_reg_write_arbiter_fifo #(.DEPTH(FIFO_DEPTH)) fifo (
        .clk(clk),
        .rst(rst),
        .push(push),
        .pop(pop),
        .pushData(longReq),
        .headData(head),
        .count(count),
        .entryValid(entryValid),
        .entryAddr(entryAddr)
    );
    // Head age counts cycles the queued head is passed over; a pop or an empty FIFO restarts it.
    always_ff @(posedge clk)
        if (rst || pop || count == '0) age <= '0;
        else age <= (age == AW'(MAX_WAIT)) ? age : age + 1'b1;
    // Registered write port: the granted entry lands here one cycle after the grant.
    always_ff @(posedge clk)
        if (rst) begin
            bus.regWriteEnable <= 1'b0;
            bus.regWriteAddr <= '0;
            bus.regWriteValue <= '0;
        end else if (pipeGrant) begin
            bus.regWriteEnable <= bus.pipeAddr != '0;
            bus.regWriteAddr <= bus.pipeAddr;
            bus.regWriteValue <= bus.pipeValue;
        end else if (pop) begin
            bus.regWriteEnable <= head.addr != '0;
            bus.regWriteAddr <= head.addr;
            bus.regWriteValue <= head.value;
        end else bus.regWriteEnable <= 1'b0;
endmodule
